cpu_dbg_target: RTL and testbench



---
 rtl/cpu_dbg_target_if.sv | 53 +++++
 rtl/cpu_dbg_target.sv | 180 ++++++++++++++++++
 tb/tb_cpu_dbg_target.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_dbg_target_if.sv
// -----------------------------------------------------------------------------
// cpu_dbg_target_if
//   CPU-side debug bus between the serial debug unit and the CPU it
//   controls. The debug unit is the master. It issues run/step/halt pulses,
//   writes the breakpoint and selects a debug channel. The CPU (or its
//   stand-in, cpu_dbg_target) is the slave. It returns the selected debug
//   word and its execution status.
//
//   Parameters:
//     DW     data/PC width in bits
//     SEL_W  debug channel select width
//
//   Signals (direction as seen by the slave):
//     run       in   1      1-cycle pulse: enter free-run
//     step      in   1      1-cycle pulse: execute one cycle, then halt
//     halt      in   1      1-cycle pulse: stop execution
//     brk_we    in   1      load brk_addr into the breakpoint register
//     brk_addr  in   DW     breakpoint PC value
//     sel       in   SEL_W  debug channel select
//     dbg_dout  out  DW     selected debug word
//     pc        out  DW     current PC
//     npc       out  DW     next PC
//     halted    out  1      core is idle or halted
//     brk_hit   out  1      1-cycle pulse when execution stops on a breakpoint
// -----------------------------------------------------------------------------
interface cpu_dbg_target_if #(
  parameter int DW    = 32,
  parameter int SEL_W = 4
);
  logic             run;
  logic             step;
  logic             halt;
  logic             brk_we;
  logic [DW-1:0]    brk_addr;
  logic [SEL_W-1:0] sel;
  logic [DW-1:0]    dbg_dout;
  logic [DW-1:0]    pc;
  logic [DW-1:0]    npc;
  logic             halted;
  logic             brk_hit;

  // Debug unit side
  modport master (
    output run, step, halt, brk_we, brk_addr, sel,
    input  dbg_dout, pc, npc, halted, brk_hit
  );

  // CPU side
  modport slave (
    input  run, step, halt, brk_we, brk_addr, sel,
    output dbg_dout, pc, npc, halted, brk_hit
  );
endinterface

// File: rtl/cpu_dbg_target.sv
// -----------------------------------------------------------------------------
// cpu_dbg_target
//   Parametrised stand-in CPU core used to bring up the serial debug unit.
//   It produces a wrapping PC stream under run/step/halt control. It counts
//   all clock cycles and all retired (executed) cycles. It exposes a bank of
//   N_CH debug words that the debug unit selects with sel.
//
//   Optional feature: define CPU_DBG_BRK_EN to enable the PC breakpoint
//   (brk_reg, brk_hit). Without it the breakpoint inputs are ignored,
//   brk_hit is held at 0 and debug channel 6 reads 0.
//
//   Ports:
//     clk_cpu  in   CPU clock. All state updates happen on its rising edge.
//     rstn     in   asynchronous active-low reset
//     bus      cpu_dbg_target_if.slave (run/step/halt/brk_we/brk_addr/sel in;
//              dbg_dout/pc/npc/halted/brk_hit out)
//
//   Debug channel map (sel):
//     0 pc    1 npc    2 ir = {pc[lo half], ~pc[lo half]}    3 cyc_cnt
//     4 ret_cnt    5 state (IDLE=0 RUN=1 STEP=2 HALT=3)    6 brk_reg
//     7..N_CH-1 constant equal to the channel index (reserved)
// -----------------------------------------------------------------------------
module cpu_dbg_target #(
  parameter int            DW       = 32,
  parameter logic [DW-1:0] PC_BASE  = DW'(32'h0000_0000),
  parameter logic [DW-1:0] PC_LIMIT = DW'(32'h0000_000A),
  parameter int            PC_INC   = 1,
  parameter int            N_CH     = 16,
  parameter int            SEL_W    = 4
) (
  input  logic              clk_cpu,
  input  logic              rstn,
  cpu_dbg_target_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [DW-1:0] PC_STEP = DW'(PC_INC);

  state_t        state_reg;
  logic [DW-1:0] pc_reg;
  logic [DW-1:0] cyc_cnt_reg;
  logic [DW-1:0] ret_cnt_reg;
  logic          halted_reg;
  logic          brk_hit_reg;
  logic [DW-1:0] npc;

`ifdef CPU_DBG_BRK_EN
  logic [DW-1:0] brk_reg;
  // Set when RUN is entered from a stopped state. It masks the breakpoint
  // compare for the first execute cycle, so a resume always leaves the PC
  // it stopped on.
  logic          brk_skip_reg;
`endif

  // Next PC wraps to PC_BASE once the current PC has reached PC_LIMIT.
  // The addition is DW bits wide and any carry out is discarded.
  assign npc = (pc_reg >= PC_LIMIT) ? PC_BASE : pc_reg + PC_STEP;

  // ---------------------------------------------------------------------------
  // Control FSM, counters and registered status outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_cpu or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      pc_reg       <= PC_BASE;
      cyc_cnt_reg  <= '0;
      ret_cnt_reg  <= '0;
      halted_reg   <= 1'b1;
      brk_hit_reg  <= 1'b0;
`ifdef CPU_DBG_BRK_EN
      brk_reg      <= '1;
      brk_skip_reg <= 1'b0;
`endif
    end else begin
      cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
      brk_hit_reg <= 1'b0;

`ifdef CPU_DBG_BRK_EN
      if (bus.brk_we) begin
        brk_reg <= bus.brk_addr;
      end
`endif

      case (state_reg)
        // Stopped: only accept commands, never execute. Priority is
        // halt > step > run.
        IDLE, HALT: begin
          if (bus.halt) begin
            state_reg  <= HALT;
            halted_reg <= 1'b1;
          end else if (bus.step) begin
            state_reg  <= STEP;
            halted_reg <= 1'b0;
          end else if (bus.run) begin
            state_reg    <= RUN;
            halted_reg   <= 1'b0;
`ifdef CPU_DBG_BRK_EN
            brk_skip_reg <= 1'b1;
`endif
          end
        end

        // Free-run: execute every cycle unless a halt arrives. A step
        // command is ignored in this state.
        RUN: begin
          if (bus.halt) begin
            state_reg  <= HALT;
            halted_reg <= 1'b1;
          end else begin
            pc_reg      <= npc;
            ret_cnt_reg <= ret_cnt_reg + 1'b1;
`ifdef CPU_DBG_BRK_EN
            brk_skip_reg <= 1'b0;
            // The breakpoint PC itself is executed into. The core then
            // stops with pc equal to brk_reg.
            if (!brk_skip_reg && (npc == brk_reg)) begin
              state_reg   <= HALT;
              halted_reg  <= 1'b1;
              brk_hit_reg <= 1'b1;
            end
`endif
          end
        end

        // Single step: one execute cycle, then stop regardless of
        // commands. The breakpoint is not checked here.
        STEP: begin
          pc_reg      <= npc;
          ret_cnt_reg <= ret_cnt_reg + 1'b1;
          state_reg   <= HALT;
          halted_reg  <= 1'b1;
        end

        default: begin
          state_reg  <= HALT;
          halted_reg <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Debug read bank
  // ---------------------------------------------------------------------------
  logic [DW-1:0] ch_word [N_CH];

  assign ch_word[0] = pc_reg;
  assign ch_word[1] = npc;
  assign ch_word[2] = {pc_reg[DW/2-1:0], ~pc_reg[DW/2-1:0]};
  assign ch_word[3] = cyc_cnt_reg;
  assign ch_word[4] = ret_cnt_reg;
  assign ch_word[5] = {{(DW-2){1'b0}}, state_reg};

`ifdef CPU_DBG_BRK_EN
  assign ch_word[6] = brk_reg;
`else
  assign ch_word[6] = '0;
  // The breakpoint inputs have no function in this build.
  logic unused_brk;
  assign unused_brk = ^{bus.brk_we, bus.brk_addr};
`endif

  // Reserved channels return their own index.
  for (genvar gi = 7; gi < N_CH; gi++) begin : g_const_ch
    assign ch_word[gi] = DW'(gi);
  end

  assign bus.dbg_dout = ch_word[bus.sel];
  assign bus.pc       = pc_reg;
  assign bus.npc      = npc;
  assign bus.halted   = halted_reg;
  assign bus.brk_hit  = brk_hit_reg;

endmodule

// File: tb/tb_cpu_dbg_target.sv
// -----------------------------------------------------------------------------
// tb_cpu_dbg_target
//   Directed testbench for cpu_dbg_target with default parameters
//   (PC 0..A wrap). It drives the debug bus interface and compares the
//   outputs against hand-computed values. The breakpoint section follows
//   CPU_DBG_BRK_EN.
// -----------------------------------------------------------------------------
module tb_cpu_dbg_target;
  localparam int DW    = 32;
  localparam int SEL_W = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  cpu_dbg_target_if #(.DW(DW), .SEL_W(SEL_W)) bus_if ();

  cpu_dbg_target dut (
    .clk_cpu (clk),
    .rstn    (rstn),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // One clock edge; sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_ch(input logic [SEL_W-1:0] s, input logic [31:0] exp, input string tag);
    bus_if.sel = s;
    #1;
    check(tag, bus_if.dbg_dout, exp);
  endtask

  task automatic pulse(input logic r, input logic s, input logic h);
    bus_if.run  = r;
    bus_if.step = s;
    bus_if.halt = h;
    tick();
    bus_if.run  = 1'b0;
    bus_if.step = 1'b0;
    bus_if.halt = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pc_run [12];
    exp_pc_run = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6,
                   32'h7, 32'h8, 32'h9, 32'hA, 32'h0, 32'h1};

    bus_if.run      = 1'b0;
    bus_if.step     = 1'b0;
    bus_if.halt     = 1'b0;
    bus_if.brk_we   = 1'b0;
    bus_if.brk_addr = '0;
    bus_if.sel      = '0;

    // ---- 1. reset and idle ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pc", bus_if.pc, 32'h0);
    check("rst_halted", {31'b0, bus_if.halted}, 32'h1);
    check("rst_brk_hit", {31'b0, bus_if.brk_hit}, 32'h0);
    read_ch(4'd2, 32'h0000_FFFF, "rst_ir");
`ifdef CPU_DBG_BRK_EN
    read_ch(4'd6, 32'hFFFF_FFFF, "rst_brk_reg");
`else
    read_ch(4'd6, 32'h0, "rst_ch6");
`endif
    rstn = 1'b1;
    repeat (5) tick();
    check("idle_pc", bus_if.pc, 32'h0);
    check("idle_halted", {31'b0, bus_if.halted}, 32'h1);
    read_ch(4'd3, 32'd5, "idle_cyc");
    read_ch(4'd4, 32'd0, "idle_ret");
    read_ch(4'd5, 32'd0, "idle_state");
    read_ch(4'd9, 32'd9, "idle_ch9");

    // ---- 2. free run, 12 execute cycles ----
    pulse(1'b1, 1'b0, 1'b0);
    check("run_entry_pc", bus_if.pc, 32'h0);
    check("run_halted", {31'b0, bus_if.halted}, 32'h0);
    read_ch(4'd5, 32'd1, "run_state");
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("run_pc%0d", i), bus_if.pc, exp_pc_run[i]);
    end
    read_ch(4'd1, 32'h2, "run_npc");
    read_ch(4'd4, 32'd12, "run_ret");
    read_ch(4'd3, 32'd18, "run_cyc");
    read_ch(4'd2, 32'h0001_FFFE, "run_ir");

    // ---- 3. halt at pc=3, then three steps ----
    repeat (2) tick();
    check("pre_halt_pc", bus_if.pc, 32'h3);
    pulse(1'b0, 1'b0, 1'b1);
    check("halt_pc", bus_if.pc, 32'h3);
    check("halt_halted", {31'b0, bus_if.halted}, 32'h1);
    read_ch(4'd5, 32'd3, "halt_state");
    read_ch(4'd4, 32'd14, "halt_ret");
    for (int k = 0; k < 3; k++) begin
      pulse(1'b0, 1'b1, 1'b0);
      check($sformatf("step%0d_in_step", k), {31'b0, bus_if.halted}, 32'h0);
      tick();
      check($sformatf("step%0d_pc", k), bus_if.pc, 32'(4 + k));
      check($sformatf("step%0d_halted", k), {31'b0, bus_if.halted}, 32'h1);
      tick();
      check($sformatf("step%0d_gap_pc", k), bus_if.pc, 32'(4 + k));
    end
    read_ch(4'd4, 32'd17, "step_ret");
    read_ch(4'd3, 32'd30, "step_cyc");

    // ---- 4. simultaneous commands ----
    pulse(1'b1, 1'b0, 1'b1);
    read_ch(4'd5, 32'd3, "runhalt_state");
    tick();
    check("runhalt_pc", bus_if.pc, 32'h6);
    pulse(1'b1, 1'b1, 1'b0);
    read_ch(4'd5, 32'd2, "steprun_state");
    check("steprun_pc0", bus_if.pc, 32'h6);
    tick();
    check("steprun_pc1", bus_if.pc, 32'h7);
    read_ch(4'd5, 32'd3, "steprun_after");
    tick();
    check("steprun_pc2", bus_if.pc, 32'h7);
    read_ch(4'd4, 32'd18, "steprun_ret");

    // ---- 6. asynchronous reset mid-run at pc=5 ----
    pulse(1'b1, 1'b0, 1'b0);
    repeat (9) tick();
    check("prerst_pc", bus_if.pc, 32'h5);
    rstn = 1'b0;
    #1;
    check("arst_pc", bus_if.pc, 32'h0);
    check("arst_halted", {31'b0, bus_if.halted}, 32'h1);
    read_ch(4'd3, 32'd0, "arst_cyc");
    read_ch(4'd4, 32'd0, "arst_ret");
    read_ch(4'd9, 32'd9, "arst_ch9");
    read_ch(4'd5, 32'd0, "arst_state");
    @(negedge clk);
    rstn = 1'b1;

    // ---- 5. breakpoint ----
    bus_if.brk_we   = 1'b1;
    bus_if.brk_addr = 32'h7;
    tick();
    bus_if.brk_we   = 1'b0;
    bus_if.brk_addr = 32'h0;
`ifdef CPU_DBG_BRK_EN
    read_ch(4'd6, 32'h7, "brk_reg");
`else
    read_ch(4'd6, 32'h0, "brk_ch6");
`endif
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check($sformatf("brk_run_pc%0d", i), bus_if.pc, 32'(i));
`ifdef CPU_DBG_BRK_EN
      check($sformatf("brk_hit_at%0d", i), {31'b0, bus_if.brk_hit}, (i == 7) ? 32'h1 : 32'h0);
`else
      check($sformatf("brk_hit_at%0d", i), {31'b0, bus_if.brk_hit}, 32'h0);
`endif
    end
`ifdef CPU_DBG_BRK_EN
    check("brk_halted", {31'b0, bus_if.halted}, 32'h1);
    read_ch(4'd5, 32'd3, "brk_state");
    tick();
    check("brk_pulse_end", {31'b0, bus_if.brk_hit}, 32'h0);
    check("brk_hold_pc", bus_if.pc, 32'h7);
    pulse(1'b1, 1'b0, 1'b0);
    tick();
    check("resume_pc", bus_if.pc, 32'h8);
    check("resume_brk_hit", {31'b0, bus_if.brk_hit}, 32'h0);
`else
    check("nobrk_halted", {31'b0, bus_if.halted}, 32'h0);
    tick();
    check("nobrk_pc", bus_if.pc, 32'h8);
    check("nobrk_brk_hit", {31'b0, bus_if.brk_hit}, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
